// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the multicycle core and an external master.
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests (default: core priority).
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic              owner_r;      // 1 = ext owns the access in flight
    logic              we_r;
    logic [2:0]        cnt_r;
    logic              any_req_s;
    logic              pick_ext_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sample_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_ext_r;
`endif

    // Arbitration and selection of the winning requester's attributes.
    always_comb begin
        any_req_s = core_req | ext_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (core_req && ext_req) begin
            pick_ext_s = ~last_ext_r;
        end else begin
            pick_ext_s = ~core_req;
        end
`else
        pick_ext_s = ~core_req;
`endif
        if (pick_ext_s) begin
            sel_we_s    = ext_we;
            sel_addr_s  = ext_addr;
            sel_wdata_s = ext_wdata;
        end else begin
            sel_we_s    = core_we;
            sel_addr_s  = core_addr;
            sel_wdata_s = core_wdata;
        end
        sample_s = (state_r == WAIT) && (cnt_r == 3'd1);
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (cnt_r == 3'd1) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, latched request attributes and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            cnt_r       <= 3'd0;
            core_gnt    <= 1'b0;
            ext_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            ext_rvalid  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy        <= (next_state_s != IDLE);
            core_gnt    <= (state_r == IDLE) && any_req_s && !pick_ext_s;
            ext_gnt     <= (state_r == IDLE) && any_req_s && pick_ext_s;
            mem_en      <= (state_r == IDLE) && any_req_s;
            mem_we      <= (state_r == IDLE) && any_req_s && sel_we_s;
            core_rvalid <= sample_s && !owner_r;
            ext_rvalid  <= sample_s && owner_r;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner_r   <= pick_ext_s;
                        we_r      <= sel_we_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= sel_wdata_s;
                    end
                end
                ISSUE: cnt_r <= LAT_INIT;
                WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                    // Memory data is valid exactly MEM_LATENCY cycles after the strobe.
                    if (cnt_r == 3'd1) begin
                        rdata <= we_r ? {DATA_W{1'b0}} : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who won last; reset to ext so the core wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_ext_r <= 1'b1;
        end else if ((state_r == IDLE) && any_req_s) begin
            last_ext_r <= pick_ext_s;
        end
    end
`endif

endmodule
